board_labels: RTL and testbench
===============================

BOARD_LABELS -- requirements
Module: board_labels

Interface
REQ-001 SHALL have parameter BOARD_X0, default 256, meaning the board left edge hcount.
REQ-002 SHALL have parameter BOARD_Y0, default 128, meaning the board top edge vcount.
REQ-003 SHALL have parameter SQ_LOG2, default 6, meaning log2 of the square size in pixels; legal values are 5..7.
REQ-004 SHALL have parameter N_SQ, default 8, meaning squares per side; legal values are 2..8.
REQ-005 SHALL have the following ports (name, direction, width, meaning):
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- vga_in  vga_if.in  -  timing input (hcount, vcount, syncs, blanks).
- vga_out  vga_if.out  -  vga_in delayed by 2 cycles.
- flip_req  in  1  requested board orientation; 1 means viewed from the black side.
- char_addr  out  11  font ROM address {char_code[6:0], glyph_line[3:0]}.
- char_col  out  3  pixel column within the 8-pixel glyph.
- label_en  out  1  current pixel lies inside a glyph cell.

Function
REQ-006 Derived constants SHALL be S = 2^SQ_LOG2 and E = N_SQ*S.
- All coordinate arithmetic SHALL use 12-bit signed differences.
- There SHALL be no wrap when a coordinate is below an origin.
REQ-007 There SHALL be four label strips:
- Top: y in [Y0-24, Y0-9].
- Bottom: y in [Y0+E+8, Y0+E+23].
- Both top and bottom SHALL span x in [X0, X0+E-1].
- Left: x in [X0-20, X0-13].
- Right: x in [X0+E+12, X0+E+19].
- Both left and right SHALL span y in [Y0, Y0+E-1].
REQ-008 File glyph cell (top/bottom strips):
- Position: x offset within the square in [S/2-4, S/2+3].
- Index: file i = (x-X0)>>SQ_LOG2.
- glyph_line = y minus the strip start.
- char_col = x offset minus (S/2-4).
REQ-009 Rank glyph cell (left/right strips):
- Position: y offset within the square in [S/2-8, S/2+7].
- Index: rank j = (y-Y0)>>SQ_LOG2.
- glyph_line = y offset minus (S/2-8).
- char_col = x minus the strip start.
REQ-010 Character codes:
- Unflipped: file code = "1"+i; rank code = "A"+(N_SQ-1-j).
- Flipped: file code = "1"+(N_SQ-1-i); rank code = "A"+j.
REQ-011 Outside a glyph cell, including strip corners and gaps, char_addr, char_col and label_en SHALL all be 0.
REQ-012 The pipeline SHALL be 2 stages.
- Stage 1 registers the strip/cell decode, index and offsets.
- Stage 2 registers code generation and the outputs.
- Outputs SHALL be aligned with vga_out, i.e. 2 cycles after vga_in.
REQ-013 Orientation control SHALL be a 2-state FSM (NORMAL, FLIPPED).
- A transition SHALL occur only on the cycle where vga_in.hcount==0 and vga_in.vcount==0.
- At that cycle the next state is FLIPPED if flip_req==1, else NORMAL.
- flip_req changes mid-frame SHALL have no effect until the next frame start.
REQ-014 A glitch on flip_req that does not coincide with a frame start SHALL be ignored.
REQ-015 The state in effect SHALL be the one sampled at stage 1 for that pixel.
- A pixel at frame start SHALL use the newly latched orientation.

Reset
REQ-016 While rst=1, on each clk edge:
- All pipeline registers, char_addr, char_col and label_en SHALL clear to 0.
- All vga_out fields SHALL clear to 0.
- The FSM SHALL return to NORMAL.
REQ-017 After rst deasserts mid-frame:
- Outputs SHALL be valid from the 3rd cycle onward.
- The FSM SHALL stay NORMAL until the next frame start, regardless of flip_req.

Verification
REQ-018 The bench SHALL cover the following scenarios (default parameters):
- Top file label: NORMAL, hcount=284, vcount=105 -> 2 cycles later char_addr=0x311, char_col=0, label_en=1.
- Left rank label: NORMAL, hcount=236, vcount=152 -> char_addr=0x480 ('H', line 0), label_en=1; same pixel in FLIPPED -> char_addr=0x410 ('A').
- Deferred flip: flip_req raised at vcount=300 -> labels unchanged for the rest of the frame; first pixel after hcount=0, vcount=0 uses FLIPPED codes (top-left file = '8', 0x381 at vcount=105).
- Boundaries: hcount=292, vcount=105 -> label_en=0, char_addr=0. Corner hcount=240, vcount=110 -> 0. Right strip hcount=780, vcount=152 -> 0x480, char_col=0.
- Bottom strip, last line: hcount=732, vcount=663 -> char_addr=0x38F ('8', line 15).
- Reset mid-line: rst pulsed 1 cycle while label_en=1 -> the next outputs are all 0 and the FSM is NORMAL.

Source files
------------

// File: rtl/vga_if.sv
// VGA raster timing bundle: pixel counters plus sync/blank strobes.
interface vga_if;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblank;
    logic        vblank;

    modport in  (input  hcount, vcount, hsync, vsync, hblank, vblank);
    modport out (output hcount, vcount, hsync, vsync, hblank, vblank);
endinterface

// File: rtl/board_labels.sv
// Chessboard file/rank label generator: decodes the raster position into a font ROM
// address for the glyph under the beam, two cycles behind the incoming timing.
module board_labels #(
    parameter int BOARD_X0 = 256,
    parameter int BOARD_Y0 = 128,
    parameter int SQ_LOG2  = 6,
    parameter int N_SQ     = 8
) (
    input  logic        clk,
    input  logic        rst,
    vga_if.in           vga_in,
    vga_if.out          vga_out,
    input  logic        flip_req,
    output logic [10:0] char_addr,
    output logic [2:0]  char_col,
    output logic        label_en
);
    localparam int S  = 1 << SQ_LOG2;
    localparam int E  = N_SQ * S;
    localparam int VW = 26;

    typedef logic signed [11:0] coord_t;
    typedef enum logic {NORMAL, FLIPPED} orient_t;

    localparam coord_t X_ORG   = coord_t'(BOARD_X0);
    localparam coord_t Y_ORG   = coord_t'(BOARD_Y0);
    localparam coord_t EDGE_HI = coord_t'(E - 1);
    localparam coord_t TOP_LO  = -12'sd24;
    localparam coord_t TOP_HI  = -12'sd9;
    localparam coord_t BOT_LO  = coord_t'(E + 8);
    localparam coord_t BOT_HI  = coord_t'(E + 23);
    localparam coord_t LFT_LO  = -12'sd20;
    localparam coord_t LFT_HI  = -12'sd13;
    localparam coord_t RGT_LO  = coord_t'(E + 12);
    localparam coord_t RGT_HI  = coord_t'(E + 19);

    localparam logic [SQ_LOG2-1:0] FILE_LO = SQ_LOG2'(S / 2 - 4);
    localparam logic [SQ_LOG2-1:0] FILE_HI = SQ_LOG2'(S / 2 + 3);
    localparam logic [SQ_LOG2-1:0] RANK_LO = SQ_LOG2'(S / 2 - 8);
    localparam logic [SQ_LOG2-1:0] RANK_HI = SQ_LOG2'(S / 2 + 7);
    localparam logic [2:0]         LAST_IDX = 3'(N_SQ - 1);

    function automatic logic in_rng(coord_t v, coord_t lo, coord_t hi);
        return (v >= lo) && (v <= hi);
    endfunction

    // Orientation FSM
    orient_t state;
    logic    frame_start;
    logic    flip_now;

    assign frame_start = (vga_in.hcount == '0) && (vga_in.vcount == '0);
    // The frame-start pixel already sees the orientation being latched on this edge.
    assign flip_now    = frame_start ? flip_req : (state == FLIPPED);

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= NORMAL;
        end else if (frame_start) begin
            state <= flip_req ? FLIPPED : NORMAL;
        end
    end

    // Stage 1 decode
    coord_t             dx, dy;
    logic [SQ_LOG2-1:0] xoff, yoff;
    logic               file_cell, rank_cell;
    logic [2:0]         idx;

    assign dx   = coord_t'({1'b0, vga_in.hcount}) - X_ORG;
    assign dy   = coord_t'({1'b0, vga_in.vcount}) - Y_ORG;
    assign xoff = dx[SQ_LOG2-1:0];
    assign yoff = dy[SQ_LOG2-1:0];

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        file_cell = 1'b0;
        rank_cell = 1'b0;
        idx       = '0;
        if ((in_rng(dy, TOP_LO, TOP_HI) || in_rng(dy, BOT_LO, BOT_HI)) &&
            in_rng(dx, '0, EDGE_HI) && xoff >= FILE_LO && xoff <= FILE_HI) begin
            file_cell = 1'b1;
            idx       = dx[SQ_LOG2+2 -: 3];
        end else if ((in_rng(dx, LFT_LO, LFT_HI) || in_rng(dx, RGT_LO, RGT_HI)) &&
                     in_rng(dy, '0, EDGE_HI) && yoff >= RANK_LO && yoff <= RANK_HI) begin
            rank_cell = 1'b1;
            idx       = dy[SQ_LOG2+2 -: 3];
        end
    end

    logic          s1_en, s1_file, s1_flip;
    logic [2:0]    s1_idx, s1_col;
    logic [3:0]    s1_line;
    logic [VW-1:0] v_in, v1, v2;

    assign v_in = {vga_in.hcount, vga_in.vcount, vga_in.hsync, vga_in.vsync,
                   vga_in.hblank, vga_in.vblank};

    // Every strip/cell start is 8 mod 16 in y and 4 mod 8 in x relative to the origin
    // (S >= 32, E a multiple of S), so line and column reduce to low-bit adds.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_en   <= 1'b0;
            s1_file <= 1'b0;
            s1_flip <= 1'b0;
            s1_idx  <= '0;
            s1_col  <= '0;
            s1_line <= '0;
            v1      <= '0;
        end else begin
            s1_en   <= file_cell | rank_cell;
            s1_file <= file_cell;
            s1_flip <= flip_now;
            s1_idx  <= idx;
            s1_col  <= dx[2:0] + 3'd4;
            s1_line <= dy[3:0] + 4'd8;
            v1      <= v_in;
        end
    end

    // Stage 2 code generation
    logic [2:0] num;
    logic [6:0] code;

    always_comb begin
        num  = s1_idx;
        if (s1_file == s1_flip) begin
            num = LAST_IDX - s1_idx;
        end
        code = (s1_file ? 7'h31 : 7'h41) + {4'b0, num};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            char_addr <= '0;
            char_col  <= '0;
            label_en  <= 1'b0;
            v2        <= '0;
        end else begin
            char_addr <= s1_en ? {code, s1_line} : '0;
            char_col  <= s1_en ? s1_col : '0;
            label_en  <= s1_en;
            v2        <= v1;
        end
    end

    assign {vga_out.hcount, vga_out.vcount, vga_out.hsync, vga_out.vsync,
            vga_out.hblank, vga_out.vblank} = v2;
endmodule

// File: tb/tb_board_labels.sv
// Bench for board_labels: vector table and sweeps scored through a latency-tagged
// queue, plus hand sequences for deferred flip and mid-line reset.
module tb_board_labels;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flip_req = 1'b0;
    logic [10:0] char_addr;
    logic [2:0]  char_col;
    logic        label_en;

    vga_if vin ();
    vga_if vout ();

    board_labels dut (
        .clk       (clk),
        .rst       (rst),
        .vga_in    (vin),
        .vga_out   (vout),
        .flip_req  (flip_req),
        .char_addr (char_addr),
        .char_col  (char_col),
        .label_en  (label_en)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int          due;
        int          tag;
        logic [10:0] addr;
        logic [2:0]  col;
        logic        en;
        logic [25:0] vga;
    } exp_t;

    typedef struct {
        logic [10:0] h;
        logic [10:0] v;
        logic        flip;
        logic [10:0] addr;
        logic [2:0]  col;
        logic        en;
    } vec_t;

    exp_t sbq[$];
    vec_t vecs[20];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [25:0] vout_flat();
        return {vout.hcount, vout.vcount, vout.hsync, vout.vsync, vout.hblank, vout.vblank};
    endfunction

    // Independent reference for the default geometry (X0=256, Y0=128, S=64, E=512).
    function automatic void model(input int h, input int v, input bit f,
                                  output logic [10:0] addr, output logic [2:0] col,
                                  output logic en);
        int x, y, k, line, c, code;
        x = h - 256;
        y = v - 128;
        addr = '0; col = '0; en = 1'b0;
        line = 0; c = 0; code = 0;
        if (x >= 0 && x < 512 && ((y >= -24 && y <= -9) || (y >= 520 && y <= 535)) &&
            (x % 64) >= 28 && (x % 64) <= 35) begin
            k    = x / 64;
            code = f ? ('h31 + 7 - k) : ('h31 + k);
            line = (y < 0) ? y + 24 : y - 520;
            c    = (x % 64) - 28;
            en   = 1'b1;
        end else if (y >= 0 && y < 512 && ((x >= -20 && x <= -13) || (x >= 524 && x <= 531)) &&
                     (y % 64) >= 24 && (y % 64) <= 39) begin
            k    = y / 64;
            code = f ? ('h41 + k) : ('h41 + 7 - k);
            line = (y % 64) - 24;
            c    = (x < 0) ? x + 20 : x - 524;
            en   = 1'b1;
        end
        if (en) begin
            addr = 11'(code * 16 + line);
            col  = 3'(c);
        end
    endfunction

    task automatic set_pix(input logic [10:0] h, input logic [10:0] v, input logic f);
        @(posedge clk);
        #1;
        vin.hcount = h;
        vin.vcount = v;
        {vin.hsync, vin.vsync, vin.hblank, vin.vblank} = 4'($urandom);
        flip_req = f;
    endtask

    task automatic drive(input logic [10:0] h, input logic [10:0] v, input logic f,
                         input logic [10:0] a, input logic [2:0] c, input logic en,
                         input int tag);
        exp_t e;
        set_pix(h, v, f);
        e.due  = cyc + 2;
        e.tag  = tag;
        e.addr = a;
        e.col  = c;
        e.en   = en;
        e.vga  = {h, v, vin.hsync, vin.vsync, vin.hblank, vin.vblank};
        sbq.push_back(e);
    endtask

    task automatic drain();
        int k = 0;
        while (sbq.size() > 0 && k < 10) begin
            @(negedge clk);
            #1;
            k++;
        end
        check("scoreboard drain", 32'(sbq.size()), 32'd0);
    endtask

    always @(negedge clk) begin
        while (sbq.size() > 0 && sbq[0].due <= cyc) begin
            exp_t e;
            e = sbq.pop_front();
            check($sformatf("t%0d char_addr", e.tag), 32'(char_addr), 32'(e.addr));
            check($sformatf("t%0d char_col", e.tag), 32'(char_col), 32'(e.col));
            check($sformatf("t%0d label_en", e.tag), 32'(label_en), 32'(e.en));
            check($sformatf("t%0d vga_out", e.tag), 32'(vout_flat()), 32'(e.vga));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [10:0] a;
        logic [2:0]  c;
        logic        en;

        vecs = '{
            '{11'd284, 11'd105, 1'b0, 11'h311, 3'd0, 1'b1},
            '{11'd236, 11'd152, 1'b0, 11'h480, 3'd0, 1'b1},
            '{11'd236, 11'd152, 1'b1, 11'h410, 3'd0, 1'b1},
            '{11'd292, 11'd105, 1'b0, 11'h000, 3'd0, 1'b0},
            '{11'd240, 11'd110, 1'b0, 11'h000, 3'd0, 1'b0},
            '{11'd780, 11'd152, 1'b0, 11'h480, 3'd0, 1'b1},
            '{11'd732, 11'd663, 1'b0, 11'h38F, 3'd0, 1'b1},
            '{11'd284, 11'd105, 1'b1, 11'h381, 3'd0, 1'b1},
            '{11'd291, 11'd104, 1'b0, 11'h310, 3'd7, 1'b1},
            '{11'd243, 11'd167, 1'b0, 11'h48F, 3'd7, 1'b1},
            '{11'd243, 11'd168, 1'b0, 11'h000, 3'd0, 1'b0},
            '{11'd284, 11'd120, 1'b0, 11'h000, 3'd0, 1'b0},
            '{11'd284, 11'd103, 1'b0, 11'h000, 3'd0, 1'b0},
            '{11'd236, 11'd600, 1'b0, 11'h410, 3'd0, 1'b1},
            '{11'd236, 11'd600, 1'b1, 11'h480, 3'd0, 1'b1},
            '{11'd787, 11'd615, 1'b1, 11'h48F, 3'd7, 1'b1},
            '{11'd235, 11'd152, 1'b0, 11'h000, 3'd0, 1'b0},
            '{11'd284, 11'd648, 1'b0, 11'h310, 3'd0, 1'b1},
            '{11'd732, 11'd104, 1'b0, 11'h380, 3'd0, 1'b1},
            '{11'd763, 11'd105, 1'b0, 11'h000, 3'd0, 1'b0}
        };

        // Reset state with live-looking timing on the input
        vin.hcount = 11'd284;
        vin.vcount = 11'd105;
        {vin.hsync, vin.vsync, vin.hblank, vin.vblank} = 4'hF;
        repeat (3) @(negedge clk);
        check("reset char_addr", 32'(char_addr), 32'd0);
        check("reset char_col", 32'(char_col), 32'd0);
        check("reset label_en", 32'(label_en), 32'd0);
        check("reset vga_out", 32'(vout_flat()), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Table: latch orientation at frame start, then glitch flip_req the other way
        for (int i = 0; i < 20; i++) begin
            drive(11'd0, 11'd0, vecs[i].flip, 11'h0, 3'd0, 1'b0, 500 + i);
            drive(vecs[i].h, vecs[i].v, ~vecs[i].flip, vecs[i].addr, vecs[i].col,
                  vecs[i].en, i);
        end

        // Deferred flip: request mid-frame, honoured only at the next frame start
        drive(11'd0,   11'd0,   1'b0, 11'h000, 3'd0, 1'b0, 100);
        drive(11'd284, 11'd300, 1'b1, 11'h000, 3'd0, 1'b0, 101);
        drive(11'd284, 11'd663, 1'b1, 11'h31F, 3'd0, 1'b1, 102);
        drive(11'd0,   11'd0,   1'b1, 11'h000, 3'd0, 1'b0, 103);
        drive(11'd284, 11'd105, 1'b0, 11'h381, 3'd0, 1'b1, 104);
        drive(11'd284, 11'd663, 1'b0, 11'h38F, 3'd0, 1'b1, 105);

        // Model sweeps across a top-strip row and the right-strip column
        for (int f = 0; f < 2; f++) begin
            drive(11'd0, 11'd0, 1'(f), 11'h000, 3'd0, 1'b0, 200 + f);
            for (int h = 230; h <= 790; h++) begin
                model(h, 110, 1'(f), a, c, en);
                drive(11'(h), 11'd110, 1'($urandom), a, c, en, 1000 + h);
            end
            for (int v = 120; v <= 660; v++) begin
                model(783, v, 1'(f), a, c, en);
                drive(11'd783, 11'(v), 1'($urandom), a, c, en, 2000 + v);
            end
        end
        drain();

        // Mid-line reset while a FLIPPED label is being shown
        drive(11'd0,   11'd0,   1'b1, 11'h000, 3'd0, 1'b0, 300);
        drive(11'd284, 11'd105, 1'b1, 11'h381, 3'd0, 1'b1, 301);
        drain();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst char_addr", 32'(char_addr), 32'd0);
        check("rst char_col", 32'(char_col), 32'd0);
        check("rst label_en", 32'(label_en), 32'd0);
        check("rst vga_out", 32'(vout_flat()), 32'd0);
        @(negedge clk);
        check("rst+1 label_en", 32'(label_en), 32'd0);
        check("rst+1 char_addr", 32'(char_addr), 32'd0);
        @(negedge clk);
        check("rst+2 NORMAL char_addr", 32'(char_addr), 32'h311);
        check("rst+2 label_en", 32'(label_en), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
